// File: rtl/band_stream_checker.sv
// band_stream_checker: on-chip stimulus sequencer and result checker for the
// multi-band equalizer. Issues divided sample strobes, delays them by the DUT
// latency and compares every channel against expected data.
// Optional feature macro: CHECKER_TOLERANCE_EN adds the tolerance port and
// enables |diff| > tolerance compares; without it compares are exact.

module band_stream_checker #(
  parameter int DATA_BITS   = 16,
  parameter int CHANNELS    = 9,
  parameter int ADDR_BITS   = 20,
  parameter int START_DELAY = 20,
  parameter int DIV_RATIO   = 64,
  parameter int LATENCY     = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [ADDR_BITS-1:0]          num_samples,
`ifdef CHECKER_TOLERANCE_EN
  input  logic [DATA_BITS-1:0]          tolerance,
`endif
  output logic                          sample_ce,
  output logic [ADDR_BITS-1:0]          src_addr,
  output logic [ADDR_BITS-1:0]          exp_addr,
  output logic                          check_ce,
  input  logic [CHANNELS*DATA_BITS-1:0] dut_data,
  input  logic [CHANNELS*DATA_BITS-1:0] exp_data,
  output logic [CHANNELS-1:0]           mismatch,
  output logic [31:0]                   err_count,
  output logic [ADDR_BITS-1:0]          first_err_addr,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int               DIV_W     = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_RATIO - 1);
  localparam logic [31:0]      WARM_LAST = 32'(START_DELAY - 1);

  state_t               state;
  state_t               state_nxt;
  logic [31:0]          warm_cnt;
  logic [DIV_W-1:0]     div_cnt;
  logic [LATENCY-1:0]   dly;
  logic [ADDR_BITS-1:0] num_lat;
`ifdef CHECKER_TOLERANCE_EN
  logic [DATA_BITS-1:0] tol_lat;
`endif
  logic [CHANNELS-1:0]  chan_fail;
  logic                 src_last;
  logic                 exp_last;
  logic                 start_go;

  // Last strobe / last check of the run, and an accepted start request.
  assign src_last = (src_addr == num_lat - 1'b1);
  assign exp_last = (exp_addr == num_lat - 1'b1);
  assign start_go = start && !abort && (state == S_IDLE || state == S_DONE);

  // Per-channel compare: the difference is one bit wider so it cannot overflow.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    logic [DATA_BITS:0] diff;
    assign diff = {dut_data[k*DATA_BITS + DATA_BITS-1], dut_data[k*DATA_BITS +: DATA_BITS]}
                - {exp_data[k*DATA_BITS + DATA_BITS-1], exp_data[k*DATA_BITS +: DATA_BITS]};
`ifdef CHECKER_TOLERANCE_EN
    logic [DATA_BITS:0] mag;
    assign mag          = diff[DATA_BITS] ? (~diff + 1'b1) : diff;
    assign chan_fail[k] = (mag > {1'b0, tol_lat});
`else
    assign chan_fail[k] = (diff != '0);
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values regardless of block ordering.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; abort has priority over everything, including start.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) state_nxt = (START_DELAY == 0) ? S_RUN : S_WARMUP;
        S_WARMUP:       if (warm_cnt == WARM_LAST) state_nxt = S_RUN;
        S_RUN: begin
          if (num_lat == '0)            state_nxt = S_DONE;
          else if (sample_ce && src_last) state_nxt = S_DRAIN;
        end
        S_DRAIN:        if (check_ce && exp_last) state_nxt = S_DONE;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: strobes come straight from registered state and counters.
  always_comb begin
    sample_ce = (state == S_RUN) && (div_cnt == '0) && (num_lat != '0);
    check_ce  = dly[LATENCY-1] && (state == S_RUN || state == S_DRAIN);
    busy      = (state == S_WARMUP) || (state == S_RUN) || (state == S_DRAIN);
    done      = (state == S_DONE);
  end

  // Counters, delay line and result registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the delay line is reset with everything else; stale strobes left
    // in it would otherwise fire check_ce after reset.
    if (rst) begin
      warm_cnt       <= '0;
      div_cnt        <= '0;
      dly            <= '0;
      num_lat        <= '0;
`ifdef CHECKER_TOLERANCE_EN
      tol_lat        <= '0;
`endif
      src_addr       <= '0;
      exp_addr       <= '0;
      mismatch       <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      warm_cnt <= (state == S_WARMUP) ? warm_cnt + 32'd1 : '0;
      div_cnt  <= (state != S_RUN)    ? '0 :
                  (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (abort) begin
        // Results are held; only the in-flight strobes are discarded.
        dly <= '0;
      end else if (start_go) begin
        dly            <= '0;
        num_lat        <= num_samples;
`ifdef CHECKER_TOLERANCE_EN
        tol_lat        <= tolerance;
`endif
        src_addr       <= '0;
        exp_addr       <= '0;
        mismatch       <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        dly <= (dly << 1) | LATENCY'(sample_ce);
        if (sample_ce) src_addr <= src_addr + 1'b1;
        if (check_ce) begin
          exp_addr <= exp_addr + 1'b1;
          if (|chan_fail) begin
            mismatch <= mismatch | chan_fail;
            if (err_count != '1) err_count <= err_count + 32'd1;
            if (err_count == '0) first_err_addr <= exp_addr;
          end
        end
      end
    end
  end

endmodule

// File: doc/band_stream_checker.md
# band_stream_checker

Self-checking stream sequencer for the multi-band equalizer regression environment, synthesizable so it can run on-chip as well as in simulation. It generates the slow sample clock-enable from `clk`, issues stimulus addresses, delays the enable by the DUT latency, and compares every band output plus the summed output against expected data within a tolerance. It reports sticky per-channel mismatch flags, an error count, the first failing sample index, and a run-complete flag.

## Interface
- `DATA_BITS`, 16: width of each channel sample (signed).
- `CHANNELS`, 9: number of compared channels (8 bands + sum).
- `ADDR_BITS`, 20: sample index width.
- `START_DELAY`, 20: warm-up cycles between start and the first strobe (≥0).
- `DIV_RATIO`, 64: `clk` cycles per sample strobe (≥2).
- `LATENCY`, 64: `clk` cycles from `sample_ce` to the matching `check_ce` (≥1).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `start`, in, 1: begins a run; sampled only in IDLE/DONE.
- `abort`, in, 1: stops the run; returns to IDLE.
- `num_samples`, in, ADDR_BITS: samples per run; latched on start.
- `tolerance`, in, DATA_BITS: unsigned allowed absolute error; latched on start.
- `sample_ce`, out, 1: one-cycle sample strobe to the DUT clock_enable/stimulus.
- `src_addr`, out, ADDR_BITS: stimulus sample index.
- `exp_addr`, out, ADDR_BITS: expected-data sample index.
- `check_ce`, out, 1: compare strobe (delayed `sample_ce`).
- `dut_data`, in, CHANNELS*DATA_BITS: DUT outputs; channel k at bits [k*DATA_BITS +: DATA_BITS].
- `exp_data`, in, CHANNELS*DATA_BITS: expected values for `exp_addr`; combinational, valid in the same cycle.
- `mismatch`, out, CHANNELS: sticky per-channel failure flags.
- `err_count`, out, 32: failing samples, saturating.
- `first_err_addr`, out, ADDR_BITS: `exp_addr` of the first failing sample.
- `busy`, out, 1: high in WARMUP, RUN, and DRAIN.
- `done`, out, 1: high in DONE.

## Operation
- The state machine has five states: IDLE, WARMUP, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE/DONE, `start`=1: latch `num_samples` and `tolerance`, clear `mismatch`, `err_count`, `first_err_addr`, `src_addr`, `exp_addr` and the delay line, then go to WARMUP. `start` in any other state is ignored.
- WARMUP: lasts exactly START_DELAY cycles, then goes to RUN. If START_DELAY=0, go straight to RUN.
- RUN:
  - The divider counter is 0 on entry. `sample_ce`=1 when the counter is 0; the counter wraps at DIV_RATIO-1.
  - `src_addr` increments the cycle after each strobe.
  - After strobe number `num_samples` is issued, go to DRAIN.
  - If `num_samples`=0, go from RUN to DONE without issuing any strobe.
- Delay line: a LATENCY-deep shift register. `check_ce` = `sample_ce` delayed LATENCY cycles. It is active in RUN and DRAIN, so checks overlap issue when LATENCY > DIV_RATIO.
- Compare, on `check_ce`, for each channel k:
  - Compute diff = dut − exp, sign-extended to DATA_BITS+1.
  - The channel fails if |diff| > `tolerance`.
  - Any failing channel sets its `mismatch[k]` and increments `err_count` once (saturates at 2^32−1).
  - If this is the first failure of the run, capture `exp_addr` into `first_err_addr`.
  - `exp_addr` increments the cycle after each check.
- DRAIN: when checks performed = `num_samples`, go to DONE. `done` stays high until the next `start`.
- `abort`=1 in any state: go to IDLE the next cycle and flush the delay line. Results are held, `done`=0.
- If `abort` and `start` are high in the same cycle, `abort` wins.

## Timing
- Reset values: all outputs 0; state IDLE.
- `start` high at edge t gives WARMUP from t+1. The first `sample_ce` is at t+1+START_DELAY.
- Strobe n falls at t+1+START_DELAY+n·DIV_RATIO. Its check falls LATENCY cycles later, with `exp_addr`=n.
- `mismatch`, `err_count` and `first_err_addr` update on the edge ending the `check_ce` cycle.
- `done` rises on the cycle after the final `check_ce`, with the final counts already valid.
- Reset mid-run: asynchronous return to the reset values.

## Configuration
- `CHECKER_TOLERANCE_EN` defined: the `tolerance` port exists and compares are |diff| > tolerance.
- `CHECKER_TOLERANCE_EN` undefined: the `tolerance` port is absent and compares are exact (diff ≠ 0).

## Test plan
- Impulse run, defaults: `num_samples`=300, `exp_data` driven equal to `dut_data` → `done` after the last check; `err_count`=0; `mismatch`=0; exactly 300 `sample_ce` and 300 `check_ce` pulses.
- Strobe spacing: START_DELAY=20, DIV_RATIO=64. Start at cycle 0 → `sample_ce` at cycles 21, 85, 149; `check_ce` 64 cycles after each.
- Injected error: channel 3 off by 5 at sample 117, `tolerance`=4 → `mismatch`=9'b000001000, `err_count`=1, `first_err_addr`=117. With `tolerance`=5 → no error.
- Overlap: LATENCY=200, DIV_RATIO=64, `num_samples`=10 → all 10 checks occur, 4 of them in DRAIN; `done` one cycle after the 10th check.
- Abort at sample 50, then restart with `num_samples`=3 → abort returns to IDLE with no `done`. The restart gives no stale `check_ce`, fresh counters, and `done` after 3 checks.
- `num_samples`=0 → `done` with no strobes and `err_count`=0. Then `rst` pulsed mid-DRAIN → all outputs 0 immediately.
